mux_sel_scanner: RTL

MUX_SEL_SCANNER -- requirements
Module: mux_sel_scanner

---
 rtl/mux_scan_pkg.sv | 25 ++
 rtl/mux_4to1_dataflow.sv | 24 ++
 rtl/mux_scan_next_ch.sv | 34 +++
 rtl/mux_sel_scanner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux select scanner:
//   - state_e   : scanner FSM states (IDLE, SETTLE, DONE)
//   - ch_t      : 2-bit channel index, {S1,S0}
//   - NUM_CH    : number of mux channels (4)
//   - DWELL_MIN / DWELL_MAX : legal range of the settle time per channel
//   - CNT_W     : width of the dwell counter (holds DWELL_MAX-1)
// ---------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_CH    = 4;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 16;
    localparam int CNT_W     = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mux_4to1_dataflow.sv
// ---------------------------------------------------------------------------
// mux_4to1_dataflow
// Plain 4:1 multiplexer written as a sum of products; the scanner drives its
// selects and reads back Y.
//   A,B,C,D in  : data inputs for channels 0..3
//   S0,S1   in  : selects, channel index = {S1,S0}
//   Y       out : selected input
// ---------------------------------------------------------------------------
module mux_4to1_dataflow (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic S0,
    input  logic S1,
    output logic Y
);

    assign Y = (~S1 & ~S0 & A) |
               (~S1 &  S0 & B) |
               ( S1 & ~S0 & C) |
               ( S1 &  S0 & D);

endmodule

// File: rtl/mux_scan_next_ch.sv
// ---------------------------------------------------------------------------
// mux_scan_next_ch
// Combinational priority search for the next enabled channel.
//   mask       in  : channel enables, bit i = channel i
//   cur        in  : currently selected channel
//   from_start in  : 1 = search from channel 0 inclusive (scan launch),
//                    0 = search strictly above cur (advance)
//   next_ch    out : lowest qualifying enabled channel (0 when none)
//   none_left  out : no qualifying enabled channel exists
// ---------------------------------------------------------------------------
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  ch_t               cur,
    input  logic              from_start,
    output ch_t               next_ch,
    output logic              none_left
);

    // Walk from the top channel down so the lowest qualifying one is the
    // last assignment and therefore wins.
    always_comb begin
        next_ch   = '0;
        none_left = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                next_ch   = ch_t'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scanner.sv
// ---------------------------------------------------------------------------
// mux_sel_scanner
// Steps the selects of a downstream 4:1 mux through the enabled channels,
// waits DWELL cycles on each and records the mux output per channel.
//
// Parameter
//   DWELL      : settle cycles per channel before Y is sampled (1..16)
// Ports
//   clk        in  : clock, all state on the rising edge
//   rst_n      in  : asynchronous active-low reset
//   start      in  : scan request, only looked at in IDLE
//   mask[3:0]  in  : channel enables, captured when a scan is accepted
//   Y          in  : downstream mux output
//   S0, S1     out : mux selects, channel = {S1,S0}
//   busy       out : high in SETTLE and DONE
//   result[3:0]out : sampled Y per channel, 0 for disabled channels
//   done       out : one-cycle pulse in the DONE state
//   parity     out : XOR of result (only with MUX_SCAN_PARITY_EN defined)
//   state_dbg  out : current FSM state for observation
//
// Build option: define MUX_SCAN_PARITY_EN to add the parity output.
//
// Handshake: start is a level request; the scan is accepted on the first
// rising edge where start=1 and the FSM is IDLE. done then pulses exactly
// once per accepted scan, and result is stable from done until the next
// acceptance.
// ---------------------------------------------------------------------------
module mux_sel_scanner
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] mask,
    input  logic              Y,
    output logic              S0,
    output logic              S1,
    output logic              busy,
    output logic [NUM_CH-1:0] result,
    output logic              done,
`ifdef MUX_SCAN_PARITY_EN
    output logic              parity,
`endif
    output state_e            state_dbg
);

    if ((DWELL < DWELL_MIN) || (DWELL > DWELL_MAX)) begin : g_dwell_range
        $error("mux_sel_scanner: DWELL out of range");
    end

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_e            state_q,  state_d;
    ch_t               ch_q,     ch_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [NUM_CH-1:0] mask_q,   mask_d;
    logic [NUM_CH-1:0] result_q, result_d;

    logic [NUM_CH-1:0] search_mask;
    logic              search_from_start;
    ch_t               next_ch;
    logic              none_left;

    // In IDLE the search looks at the live mask from channel 0 to find the
    // first channel of a new scan; otherwise it advances over the captured
    // mask so mid-scan mask changes cannot leak in.
    assign search_from_start = (state_q == IDLE);
    assign search_mask       = (state_q == IDLE) ? mask : mask_q;

    mux_scan_next_ch u_next_ch (
        .mask       (search_mask),
        .cur        (ch_q),
        .from_start (search_from_start),
        .next_ch    (next_ch),
        .none_left  (none_left)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d   = mask;
                    result_d = '0;
                    if (none_left) begin
                        // Empty mask: nothing to visit, selects keep their
                        // previous channel.
                        state_d = DONE;
                    end else begin
                        ch_d    = next_ch;
                        cnt_d   = RELOAD;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    result_d[ch_q] = Y;
                    if (none_left) begin
                        state_d = DONE;
                    end else begin
                        ch_d  = next_ch;
                        cnt_d = RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            result_q <= result_d;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q, parity_d;

    // Computed from the next result so parity changes on the same edge.
    assign parity_d = ^result_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

    assign S0        = ch_q[0];
    assign S1        = ch_q[1];
    assign busy      = (state_q == SETTLE) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule
